// File: rtl/load_pkg.sv
// +----------------------------------------------------------------------------+
// | load_pkg: size encodings, FSM state type and alignment helpers shared by    |
// | the load alignment unit.                                                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package load_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD1   = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_RD2   = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return (off & mask) != 3'd0;
  endfunction

  // Access runs past the end of the current memory word.
  function automatic logic spans_words(input logic [2:0] off, input logic [1:0] size,
                                       input logic [3:0] bytes);
    return ({1'b0, off} + (4'd1 << size)) > bytes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align_unit_if.sv
// +----------------------------------------------------------------------------+
// | load_align_unit_if: request, memory-port and response signals of the load  |
// | alignment unit. slave = unit view, master = environment view.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              req_lui;
  logic [15:0]       req_imm;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned, req_lui, req_imm,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    input  resp_ready,
    output req_ready, mem_req_valid, mem_addr,
    output resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned, req_lui, req_imm,
    output mem_req_ready, mem_rvalid, mem_rdata,
    output resp_ready,
    input  req_ready, mem_req_valid, mem_addr,
    input  resp_valid, resp_data, resp_err
  );

endinterface

`default_nettype wire

// File: rtl/load_extend.sv
// +----------------------------------------------------------------------------+
// | load_extend: shifts the addressed lanes of {hi, lo} down, truncates to the |
// | access size and zero- or sign-extends to DATA_W. Purely combinational.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_extend
  import load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_keep;
  logic              w_msb;
  logic              w_fill;

  assign w_shifted = DATA_W'({hi_i, lo_i} >> {off_i, 3'b000});

  always_comb begin
    w_keep = '1;
    w_msb  = w_shifted[DATA_W-1];
    case (size_i)
      SZ_BYTE: begin
        w_keep = DATA_W'(64'h0000_0000_0000_00FF);
        w_msb  = w_shifted[7];
      end
      SZ_HALF: begin
        w_keep = DATA_W'(64'h0000_0000_0000_FFFF);
        w_msb  = w_shifted[15];
      end
      SZ_WORD: begin
        w_keep = DATA_W'(64'h0000_0000_FFFF_FFFF);
        w_msb  = w_shifted[31];
      end
      default: begin
        w_keep = '1;
        w_msb  = w_shifted[DATA_W-1];
      end
    endcase
  end

  assign w_fill = w_msb & ~unsigned_i;
  assign data_o = (w_shifted & w_keep) | (~w_keep & {DATA_W{w_fill}});

endmodule

`default_nettype wire

// File: rtl/load_align_unit.sv
// +----------------------------------------------------------------------------+
// | load_align_unit: accepts a load (or LUI), issues aligned memory reads and  |
// | returns the shifted, extended result. Build option LOAD_ALIGN_SPLIT_EN     |
// | splits word-crossing loads into two reads instead of flagging an error.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_align_unit
  import load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic             clk,
  input  logic             rst_n,
  load_align_unit_if.slave bus
);

  localparam int BYTES = DATA_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [OFF_W-1:0]  w_off;
  logic [ADDR_W-1:0] w_aligned;
  logic [DATA_W-1:0] w_ext_lo, w_ext_hi, w_ext;
  logic [DATA_W-1:0] w_lui;
  logic signed [31:0] w_lui32;
  logic              w_in_bad_size;
  logic              w_in_illegal;
  logic              w_req_ready, w_mem_valid;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_off     = addr_q[OFF_W-1:0];
  assign w_aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_lui32   = {bus.req_imm, 16'h0000};
  assign w_lui     = DATA_W'(w_lui32);

  assign w_in_bad_size = (bus.req_size == SZ_DWORD) && (DATA_W < 64);

`ifdef LOAD_ALIGN_SPLIT_EN
  logic              w_go_rd2;
  logic [ADDR_W-1:0] w_addr_hi;
  assign w_in_illegal = w_in_bad_size;
  assign w_go_rd2     = spans_words(3'(w_off), size_q, 4'(BYTES));
  // Second word wraps naturally at the top of the address space.
  assign w_addr_hi    = w_aligned + ADDR_W'(BYTES);
`else
  logic w_in_mis;
  assign w_in_mis     = is_misaligned(3'(bus.req_addr[OFF_W-1:0]), bus.req_size);
  assign w_in_illegal = w_in_bad_size | w_in_mis;
`endif

  load_extend #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_extend (
    .lo_i       (w_ext_lo),
    .hi_i       (w_ext_hi),
    .off_i      (w_off),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lo_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Result is registered on the RESP entry edge, using live read data so no
  // extra cycle is spent after the last beat.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lo_d        = lo_q;
    data_d      = data_q;
    err_d       = err_q;
    w_req_ready = 1'b0;
    w_mem_valid = 1'b0;
    w_mem_addr  = '0;
    w_ext_lo    = lo_q;
    w_ext_hi    = '0;
    case (state_q)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          data_d = '0;
          err_d  = 1'b0;
          if (bus.req_lui) begin
            data_d  = w_lui;
            state_d = ST_RESP;
          end else if (w_in_illegal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_RD1;
          end
        end
      end
      ST_RD1: begin
        w_mem_valid = 1'b1;
        w_mem_addr  = w_aligned;
        if (bus.mem_req_ready) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        w_ext_lo = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          lo_d = bus.mem_rdata;
`ifdef LOAD_ALIGN_SPLIT_EN
          if (w_go_rd2) begin
            state_d = ST_RD2;
          end else begin
            data_d  = w_ext;
            state_d = ST_RESP;
          end
`else
          data_d  = w_ext;
          state_d = ST_RESP;
`endif
        end
      end
`ifdef LOAD_ALIGN_SPLIT_EN
      ST_RD2: begin
        w_mem_valid = 1'b1;
        w_mem_addr  = w_addr_hi;
        if (bus.mem_req_ready) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        w_ext_hi = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          data_d  = w_ext;
          state_d = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.mem_req_valid = w_mem_valid;
  assign bus.mem_addr      = w_mem_addr;
  assign bus.resp_valid    = (state_q == ST_RESP);
  assign bus.resp_data     = data_q;
  assign bus.resp_err      = err_q;

endmodule

`default_nettype wire
